qmfir_result_bank: RTL and testbench
====================================

# qmfir_result_bank

Parametrised N-channel capture buffer for QM FIR outputs. Holds the last DEPTH samples of every channel in a shared-pointer circular buffer, with wrap or one-shot capture, overflow tracking and a status window. Serves host reads over the UART address space with one cycle of latency. Sits between the QM_FIR result outputs and the UART interface read mux, and replaces the per-channel fixed-size output BRAMs and their OR-combined readback.

## Interface
- NCH, 6: number of result channels; legal range 1..6.
- DW, 16: sample width and read-data width; must satisfy DW ≥ AW+1.
- AW, 7: buffer index width; DEPTH = 2^AW words per channel.
- clk  in  1  system clock; single clock domain.
- arst  in  1  reset; synchronous, active-high.
- in_valid  in  1  one sample per channel present on in_data (FIR DataValid).
- in_data  in  NCH*DW  channel c occupies bits [c*DW +: DW].
- mode  in  1  0 = wrap (continuous), 1 = one-shot (stop when full).
- clr  in  1  one-cycle pulse: clear pointer, count and overflow flag.
- host_addr  in  14  UART address; [13:11] is the region, [AW-1:0] is the index/offset.
- host_re  in  1  host read strobe.
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- count  out  AW+1  stored samples per channel; saturates at DEPTH.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky overflow flag.

## Operation
- Storage: NCH arrays of DEPTH×DW. All channels share one write pointer wptr[AW-1:0].
- Write on in_valid & ~clr:
  - count < DEPTH: store at wptr in every channel; wptr+1 mod DEPTH; count+1.
  - count == DEPTH, mode=0: store at wptr (overwrites the oldest sample); wptr+1 mod DEPTH; count holds; ovf←1.
  - count == DEPTH, mode=1: no store; wptr holds; ovf←1.
- mode is sampled every cycle. A change takes effect on the next write and does not alter stored data.
- clr: wptr←0, count←0, ovf←0. Memory is not cleared. clr takes priority over a same-cycle in_valid, and that sample is dropped.
- Read regions, selected by host_addr[13:11]:
  - Region 0 is status. Offset 0 returns {zeros, mode, ovf, full} in bits [2:0]. Offset 1 returns count, zero-extended. Any other offset returns 0.
  - Regions 1..NCH select channel region-1. The index i = host_addr[AW-1:0] is logical, and i=0 is the oldest stored sample.
  - Physical address = (oldest + i) mod DEPTH, where oldest = full ? wptr : 0.
  - i ≥ count returns 0.
  - Regions above NCH return 0.
- A read uses the pointer, count and memory state from before the clock edge. If a read and a write hit the same cycle, the read returns pre-write data (read-before-write).
- A read has no side effects. Reads are ignored while arst is high.

## Timing
- Reset, applied synchronously at the edge with arst=1: wptr=0, count=0, full=0, ovf=0, rd_data=0, rd_valid=0. Memory contents are undefined after reset.
- Write latency: a sample presented with in_valid at edge t is readable by a host_re at edge t+1 or later. count/full/ovf update at edge t.
- Read latency: host_re high at edge t gives rd_valid=1 and rd_data valid after edge t. Both are registered.
  - rd_valid returns to 0 on the following edge unless host_re is held high.
  - rd_data holds its last value while rd_valid=0.
- Back-to-back reads are allowed at one per cycle, with a throughput of one word per clk.
- in_valid may be asserted every cycle. There is no backpressure.
- Reset asserted mid-operation aborts any pending read: rd_valid=0 on the next edge.

## Test plan
- Reset, then 5 writes of channel c with value 16'h0100+k (k=0..4), then read region 1..6 index 0..4. Expect 16'h0100+k per channel on the correct lane, count=5, full=0, ovf=0. Expect rd_valid exactly one cycle after each host_re.
- Mode=0, 130 writes of value k (k=0..129). Expect count=128, full=1, ovf=1. Index 0 returns 2 and index 127 returns 129. Region 0 offset 0 reads 3'b011.
- Mode=1, 130 writes of value k. Expect index 0 returns 0, index 127 returns 127, wptr unchanged after the 128th write, ovf=1.
- clr and in_valid on the same cycle after 10 writes. Expect count=0, ovf=0. Index 0 then returns 0 (since i ≥ count), and the next write lands at physical 0.
- Read index 20 with count=5, read region 7, and read region 0 offset 5. All three return 0 with rd_valid=1.
- Read of index 3 with count=3, concurrent with a write of 16'hBEEF. Returns 0, pre-write state. A read one cycle later returns 16'hBEEF.

Source files
------------

// File: rtl/qmfir_result_bank.sv
// Multi-channel capture buffer for QM FIR results: shared circular write pointer,
// wrap or one-shot capture, sticky overflow, and a one-cycle-latency host read port.
module qmfir_result_bank #(
  parameter int NCH = 6,
  parameter int DW  = 16,
  parameter int AW  = 7
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] in_data,
  input  logic              mode,
  input  logic              clr,
  input  logic [13:0]       host_addr,
  input  logic              host_re,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic [AW:0]       count,
  output logic              full,
  output logic              ovf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0]  NCH_REGION = 3'(NCH);

  logic [AW-1:0] wptr_reg, wptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          full_int;
  logic          store;

  assign full_int = (count_reg == DEPTH_CNT);
  // One-shot mode refuses stores once full; wrap mode overwrites the oldest word.
  assign store = in_valid & ~clr & ~arst & (~full_int | ~mode);

  always_comb begin
    wptr_next  = wptr_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (clr) begin
      wptr_next  = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (in_valid) begin
      if (store) wptr_next = wptr_reg + 1'b1;
      if (full_int) ovf_next = 1'b1;
      else count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Host read decode, all from pre-edge state
  logic [2:0]    region;
  logic [AW-1:0] offset;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_phys;
  logic          rd_en;
  logic          is_chan;
  logic          in_range;
  logic [DW-1:0] status_word;
  logic          unused_addr_bits;

  assign region           = host_addr[13:11];
  assign offset           = host_addr[AW-1:0];
  assign unused_addr_bits = ^host_addr[10:AW];
  assign rd_en            = host_re & ~arst;
  assign oldest           = full_int ? wptr_reg : '0;
  assign rd_phys          = oldest + offset;
  assign is_chan          = (region != 3'd0) && (region <= NCH_REGION);
  assign in_range         = ({1'b0, offset} < count_reg);

  always_comb begin
    status_word = '0;
    if (offset == AW'(0))      status_word[2:0]  = {mode, ovf_reg, full_int};
    else if (offset == AW'(1)) status_word[AW:0] = count_reg;
  end

  logic          rd_valid_reg;
  logic          rd_use_mem_reg;
  logic [DW-1:0] rd_imm_reg;
  logic [2:0]    rd_ch_reg;

  always_ff @(posedge clk) begin
    if (arst) begin
      rd_valid_reg   <= 1'b0;
      rd_use_mem_reg <= 1'b0;
      rd_imm_reg     <= '0;
      rd_ch_reg      <= '0;
    end else begin
      rd_valid_reg <= host_re;
      if (host_re) begin
        rd_use_mem_reg <= is_chan & in_range;
        rd_imm_reg     <= (region == 3'd0) ? status_word : '0;
        rd_ch_reg      <= region - 3'd1;
      end
    end
  end

  logic [DW-1:0] ch_data [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] q_reg;

      // Non-blocking read of the same array gives read-before-write on a collision.
      always_ff @(posedge clk) begin
        if (store) mem[wptr_reg] <= in_data[gi*DW +: DW];
        if (rd_en) q_reg <= mem[rd_phys];
      end

      assign ch_data[gi] = q_reg;
    end
  endgenerate

  always_comb begin
    rd_data = rd_imm_reg;
    if (rd_use_mem_reg) begin
      for (int c = 0; c < NCH; c++) begin
        if (rd_ch_reg == 3'(c)) rd_data = ch_data[c];
      end
    end
  end

  assign rd_valid = rd_valid_reg;
  assign count    = count_reg;
  assign full     = full_int;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_qmfir_result_bank.sv
// Scoreboard bench for qmfir_result_bank: a queue-of-samples history model predicts
// every cycle's outputs; a monitor compares them one cycle after each edge.
module tb_qmfir_result_bank;

  localparam int NCH   = 6;
  localparam int DW    = 16;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              in_valid = 1'b0;
  logic [NCH*DW-1:0] in_data = '0;
  logic              mode = 1'b0;
  logic              clr = 1'b0;
  logic [13:0]       host_addr = '0;
  logic              host_re = 1'b0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              full;
  logic              ovf;

  qmfir_result_bank #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .clr(clr), .host_addr(host_addr), .host_re(host_re),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [AW:0]   cnt;
    logic          f;
    logic          o;
  } exp_t;

  exp_t              exp_q[$];
  logic [NCH*DW-1:0] hist[$];   // oldest sample first, all lanes packed per entry
  logic              m_ovf = 1'b0;
  logic [DW-1:0]     hold = '0;
  logic              cur_mode = 1'b0;
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [13:0] a, input logic md);
    int unsigned r;
    int unsigned i;
    logic [NCH*DW-1:0] ent;
    logic [DW-1:0] res;
    r = a[13:11];
    i = a[AW-1:0];
    res = '0;
    if (r == 0) begin
      if (i == 0) res = {{(DW-3){1'b0}}, md, m_ovf, hist.size() == DEPTH};
      else if (i == 1) res = DW'(hist.size());
    end else if (r <= NCH && i < hist.size()) begin
      ent = hist[i];
      res = ent[(r-1)*DW +: DW];
    end
    return res;
  endfunction

  task automatic drive(input logic iv, input logic [NCH*DW-1:0] d, input logic md,
                       input logic cl, input logic re, input logic [13:0] a, input logic rs);
    exp_t e;
    @(negedge clk);
    in_valid = iv; in_data = d; mode = md; clr = cl;
    host_re = re; host_addr = a; arst = rs;
    if (rs) begin
      hist.delete();
      m_ovf = 1'b0;
      hold = '0;
      e.v = 1'b0;
    end else begin
      if (re) hold = ref_read(a, md);
      e.v = re;
      if (cl) begin
        hist.delete();
        m_ovf = 1'b0;
      end else if (iv) begin
        if (hist.size() < DEPTH) hist.push_back(d);
        else begin
          m_ovf = 1'b1;
          if (!md) begin
            hist.delete(0);
            hist.push_back(d);
          end
        end
      end
    end
    e.d = hold;
    e.cnt = (AW+1)'(hist.size());
    e.f = (hist.size() == DEPTH);
    e.o = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic iv, input logic [NCH*DW-1:0] d, input logic cl,
                      input logic re, input logic [13:0] a);
    drive(iv, d, cur_mode, cl, re, a, 1'b0);
  endtask

  function automatic logic [13:0] ra(input int r, input int i);
    logic [13:0] a;
    a = '0;
    a[13:11] = 3'(r);
    a[AW-1:0] = AW'(i);
    return a;
  endfunction

  function automatic logic [NCH*DW-1:0] splat(input logic [DW-1:0] v);
    return {NCH{v}};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_valid", 32'(rd_valid), 32'(e.v));
        check("rd_data", 32'(rd_data), 32'(e.d));
        check("count", 32'(count), 32'(e.cnt));
        check("full", 32'(full), 32'(e.f));
        check("ovf", 32'(ovf), 32'(e.o));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [NCH*DW-1:0] d;
    logic [13:0] a;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Lane test: distinct value per lane so a lane swap is visible
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'(16'h0100 + k + (c << 12));
      step(1'b1, d, 1'b0, 1'b0, '0);
    end
    for (int ch = 1; ch <= NCH; ch++)
      for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0, 1'b1, ra(ch, k));
    step(1'b0, '0, 1'b0, 1'b1, ra(0, 0));
    step(1'b0, '0, 1'b0, 1'b1, ra(0, 1));
    step(1'b0, '0, 1'b0, 1'b0, '0);

    // Wrap mode over-run
    cur_mode = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 130; k++) step(1'b1, splat(DW'(k)), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, ra(1, 0));
    step(1'b0, '0, 1'b0, 1'b1, ra(6, 127));
    step(1'b0, '0, 1'b0, 1'b1, ra(0, 0));
    step(1'b0, '0, 1'b0, 1'b1, ra(0, 1));

    // One-shot mode over-run
    cur_mode = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 130; k++) step(1'b1, splat(DW'(k)), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, ra(2, 0));
    step(1'b0, '0, 1'b0, 1'b1, ra(3, 127));
    step(1'b0, '0, 1'b0, 1'b1, ra(0, 0));
    cur_mode = 1'b0;
    step(1'b1, splat(16'h7777), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, ra(1, 0));
    step(1'b0, '0, 1'b0, 1'b1, ra(1, 127));

    // clr colliding with in_valid
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) step(1'b1, splat(DW'(16'h0A00 + k)), 1'b0, 1'b0, '0);
    step(1'b1, splat(16'hDEAD), 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, ra(1, 0));
    step(1'b1, splat(16'h1234), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, ra(4, 0));

    // Out-of-range reads
    for (int k = 0; k < 4; k++) step(1'b1, splat(DW'(16'h0500 + k)), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, ra(1, 20));
    step(1'b0, '0, 1'b0, 1'b1, ra(7, 0));
    step(1'b0, '0, 1'b0, 1'b1, ra(0, 5));

    // Read/write collision
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) step(1'b1, splat(DW'(16'h0300 + k)), 1'b0, 1'b0, '0);
    step(1'b1, splat(16'hBEEF), 1'b0, 1'b1, ra(5, 3));
    step(1'b0, '0, 1'b0, 1'b1, ra(5, 3));
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'($urandom);
      a = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) a[AW-1:0] = AW'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) cur_mode = ~cur_mode;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 149) == 0,
           $urandom_range(0, 1) == 1, a);
    end

    // Reset mid-read aborts it
    step(1'b1, splat(16'h4444), 1'b0, 1'b1, ra(1, 0));
    drive(1'b1, splat(16'h5555), 1'b0, 1'b0, 1'b1, ra(1, 0), 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, ra(0, 1));
    step(1'b0, '0, 1'b0, 1'b0, '0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
